// File: rtl/bhl_load_reg.sv
// bhl_load_reg: parallel-load register with load enable.
//
// Captures RA into QA on a rising clk edge when LD_A is high and holds QA
// otherwise. Serves as an accumulator/operand register in the datapath, and
// also reports whether QA holds loaded data and when a load changed it.
//
// Optional feature: define BHL_LOAD_REG_PARITY_EN to add the QA_PAR output,
// the registered even parity (XOR reduction) of QA.
//
// Parameters:
//   WIDTH   - data width of RA and QA (1..64)
//   RST_VAL - value QA takes on reset
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous reset, active-low
//   LD_A   in   1      load enable; RA captured at the next rising edge
//   RA     in   WIDTH  parallel data input
//   QA     out  WIDTH  registered data output
//   QA_VLD out  1      set once a load has completed since the last reset
//   QA_CHG out  1      one-cycle pulse: previous edge loaded a different value
//   QA_PAR out  1      XOR reduction of QA (only with BHL_LOAD_REG_PARITY_EN)
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.

module bhl_load_reg #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LD_A,
  input  logic [WIDTH-1:0] RA,
  output logic [WIDTH-1:0] QA,
  output logic             QA_VLD,
`ifdef BHL_LOAD_REG_PARITY_EN
  output logic             QA_PAR,
`endif
  output logic             QA_CHG
);

  logic [WIDTH-1:0] r_qa;
  logic             r_vld;
  logic             r_chg;

  logic [WIDTH-1:0] w_qa_d;
  logic             w_vld_d;
  logic             w_chg_d;

  // Next state for an un-reset edge; reset is applied in the flop process so
  // it overrides a simultaneous load.
  always_comb begin
    w_qa_d  = r_qa;
    w_vld_d = r_vld;
    w_chg_d = 1'b0;
    if (LD_A) begin
      w_qa_d  = RA;
      w_vld_d = 1'b1;
      w_chg_d = (RA != r_qa);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_qa  <= RST_VAL;
      r_vld <= 1'b0;
      r_chg <= 1'b0;
    end else begin
      r_qa  <= w_qa_d;
      r_vld <= w_vld_d;
      r_chg <= w_chg_d;
    end
  end

`ifdef BHL_LOAD_REG_PARITY_EN
  // Parity is kept in its own flop, computed from the value being written,
  // so QA_PAR is not an XOR tree hanging off QA.
  logic r_par;
  logic w_par_d;

  always_comb begin
    w_par_d = r_par;
    if (LD_A) begin
      w_par_d = ^RA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_par <= ^RST_VAL;
    end else begin
      r_par <= w_par_d;
    end
  end

  assign QA_PAR = r_par;
`endif

  assign QA     = r_qa;
  assign QA_VLD = r_vld;
  assign QA_CHG = r_chg;

endmodule

// File: tb/tb_bhl_load_reg.sv
// Directed bench for bhl_load_reg (WIDTH=4, RST_VAL=0).
// Each vector drives rst/LD_A/RA for one edge, then compares QA, QA_VLD,
// QA_CHG (and QA_PAR when BHL_LOAD_REG_PARITY_EN is defined) against
// hand-computed values, once just after the edge and again at mid-cycle.

module tb_bhl_load_reg;

  localparam int unsigned Width = 4;
  localparam int unsigned NumVecs = 13;

  logic             clk;
  logic             rst;
  logic             LD_A;
  logic [Width-1:0] RA;
  logic [Width-1:0] QA;
  logic             QA_VLD;
  logic             QA_CHG;
`ifdef BHL_LOAD_REG_PARITY_EN
  logic             QA_PAR;
`endif

  int checks = 0;
  int errors = 0;

  bhl_load_reg #(
    .WIDTH   (Width),
    .RST_VAL (4'b0000)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .LD_A   (LD_A),
    .RA     (RA),
    .QA     (QA),
    .QA_VLD (QA_VLD),
`ifdef BHL_LOAD_REG_PARITY_EN
    .QA_PAR (QA_PAR),
`endif
    .QA_CHG (QA_CHG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic             rst;
    logic             ld;
    logic [Width-1:0] ra;
    logic [Width-1:0] qa;
    logic             vld;
    logic             chg;
    logic             par;
  } vec_t;

  vec_t vecs [NumVecs];

  initial begin
    //          rst   ld    ra       qa       vld   chg   par
    vecs[0]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0}; // reset
    vecs[1]  = '{1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0}; // hold after reset
    vecs[2]  = '{1'b1, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1}; // first load
    vecs[3]  = '{1'b1, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1}; // same value again
    vecs[4]  = '{1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0}; // overwrite
    vecs[5]  = '{1'b1, 1'b0, 4'b0101, 4'b1111, 1'b1, 1'b0, 1'b0}; // hold, RA ignored
    vecs[6]  = '{1'b1, 1'b0, 4'b0101, 4'b1111, 1'b1, 1'b0, 1'b0}; // hold again
    vecs[7]  = '{1'b1, 1'b1, 4'b0101, 4'b0101, 1'b1, 1'b1, 1'b0}; // reload
    vecs[8]  = '{1'b0, 1'b1, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0}; // reset beats load
    vecs[9]  = '{1'b1, 1'b1, 4'b1010, 4'b1010, 1'b1, 1'b1, 1'b0}; // load after release
    vecs[10] = '{1'b1, 1'b1, 4'b0011, 4'b0011, 1'b1, 1'b1, 1'b0}; // back-to-back load
    vecs[11] = '{1'b1, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1}; // back-to-back load
    vecs[12] = '{1'b1, 1'b0, 4'b0111, 4'b1000, 1'b1, 1'b0, 1'b1}; // pulse drops on hold

    rst  = 1'b0;
    LD_A = 1'b0;
    RA   = '0;
    @(negedge clk);

    for (int i = 0; i < NumVecs; i++) begin
      rst  = vecs[i].rst;
      LD_A = vecs[i].ld;
      RA   = vecs[i].ra;
      @(posedge clk);
      #1;
      check_eq($sformatf("v%0d_qa", i),  QA,     vecs[i].qa);
      check_eq($sformatf("v%0d_vld", i), QA_VLD, vecs[i].vld);
      check_eq($sformatf("v%0d_chg", i), QA_CHG, vecs[i].chg);
`ifdef BHL_LOAD_REG_PARITY_EN
      check_eq($sformatf("v%0d_par", i), QA_PAR, vecs[i].par);
`endif
      @(negedge clk);
      check_eq($sformatf("v%0d_qa_mid", i), QA, vecs[i].qa);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
